// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds PC and IR, fetches one word per instruction
// from instruction memory and presents it to the opcode controller.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH    = 8,
    parameter int OPERAND_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       imem_req,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    input  logic                       imem_ack,
    input  logic [OPERAND_WIDTH+3:0]   imem_rdata,
    input  logic                       stall,
    output logic [3:0]                 opcode,
    output logic [OPERAND_WIDTH-1:0]   operand,
    output logic                       instr_valid,
    output logic [ADDR_WIDTH-1:0]      pc,
    output logic                       halted
);

    localparam int         IW      = OPERAND_WIDTH + 4;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [IW-1:0]          ir_q, ir_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic [3:0]             ir_op;

    assign ir_op = ir_q[IW-1 -: 4];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (ir_op == OP_JMP) pc_d = ir_q[ADDR_WIDTH-1:0];
                    else                 pc_d = pc_q + ADDR_WIDTH'(1);
                    state_d = (ir_op == OP_HALT) ? S_HALTED : S_FETCH;
                end
            end
            default: state_d = S_HALTED;
        endcase
        // Output flags are registered off the next state so they track state_q exactly.
        req_d    = (state_d == S_FETCH);
        valid_d  = (state_d == S_ISSUE);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign opcode      = valid_q ? ir_op : 4'b0000;
    assign operand     = valid_q ? ir_q[OPERAND_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder model with a
// scoreboard of fetched words, a vector table for the straight-line program,
// and hand-written sequences for stall, jump/wrap, halt and reset corners.
module tb_instr_fetch_unit;

    localparam int AW = 8;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst, start, imem_ack, stall;
    logic [OW+3:0] imem_rdata;
    logic          imem_req, instr_valid, halted;
    logic [AW-1:0] imem_addr, pc;
    logic [3:0]    opcode;
    logic [OW-1:0] operand;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .OPERAND_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
        .pc(pc), .halted(halted)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] word;
        logic [3:0]  exp_op;
        logic [7:0]  exp_operand;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] opnd;
    } issue_t;

    vec_t        seq_tbl [3];
    issue_t      exp_q [$];
    issue_t      ret_log [$];
    logic [7:0]  fetch_log [$];
    logic [11:0] mem [256];

    int   n_chk = 0, n_fail = 0;
    bit   mem_en, mon_en;
    int   ack_delay, wait_cnt, stall_left, valid_ticks, req_ticks;
    bit   prev_valid, prev_stall, prev_req, prev_ack;
    logic [7:0] prev_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the next inputs.
    task automatic tick();
        issue_t e;
        @(negedge clk);
        if (mon_en) begin
            if (instr_valid) begin
                chk("sb_depth", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("sb_opcode", opcode, exp_q[0].op);
                    chk("sb_operand", operand, exp_q[0].opnd);
                end
                chk("valid_b2b_unstalled", prev_valid && !prev_stall, 0);
            end else begin
                chk("idle_opcode", opcode, 0);
                chk("idle_operand", operand, 0);
            end
            if (imem_req && prev_req && !prev_ack)
                chk("addr_stable", imem_addr, prev_addr);
        end
        stall = 1'b0;
        if (instr_valid && stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end
        if (instr_valid) valid_ticks++;
        if (imem_req)    req_ticks++;
        if (instr_valid && !stall) begin
            e.op   = opcode;
            e.opnd = operand;
            ret_log.push_back(e);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (mem_en) begin
            if (imem_req) begin
                if (wait_cnt == ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    fetch_log.push_back(imem_addr);
                    e.op   = imem_rdata[11:8];
                    e.opnd = imem_rdata[7:0];
                    exp_q.push_back(e);
                    wait_cnt = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 12'h000;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
        prev_valid = instr_valid;
        prev_stall = stall;
        prev_req   = imem_req;
        prev_ack   = imem_ack;
        prev_addr  = imem_addr;
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 12'h000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); ret_log.delete(); fetch_log.delete();
        wait_cnt = 0; stall_left = 0; valid_ticks = 0; req_ticks = 0;
        prev_valid = 0; prev_stall = 0; prev_req = 0; prev_ack = 0; prev_addr = 8'h00;
        mem_en = 1; mon_en = 1; ack_delay = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_retired(input int n, input int lim);
        int k = 0;
        while (ret_log.size() < n && k < lim) begin
            tick();
            k++;
        end
        chk("retire_timeout", ret_log.size() >= n, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 12'h000;
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;

        seq_tbl[0] = '{addr: 8'h00, word: 12'h105, exp_op: 4'h1, exp_operand: 8'h05};
        seq_tbl[1] = '{addr: 8'h01, word: 12'h20A, exp_op: 4'h2, exp_operand: 8'h0A};
        seq_tbl[2] = '{addr: 8'h02, word: 12'h3FF, exp_op: 4'h3, exp_operand: 8'hFF};

        // Reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_pc", pc, 0);
            chk("idle_req", imem_req, 0);
            chk("idle_valid", instr_valid, 0);
            chk("idle_halted", halted, 0);
        end

        // Sequential fetch, zero-wait memory
        for (int i = 0; i < 3; i++) mem[seq_tbl[i].addr] = seq_tbl[i].word;
        pulse_start();
        run_until_retired(3, 50);
        @(posedge clk); #1;
        chk("seq_pc_after3", pc, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ret_log.size()) begin
                chk("seq_opcode", ret_log[i].op, seq_tbl[i].exp_op);
                chk("seq_operand", ret_log[i].opnd, seq_tbl[i].exp_operand);
            end
            if (i < fetch_log.size()) chk("seq_fetch_addr", fetch_log[i], seq_tbl[i].addr);
        end

        // Wait states and stall
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[0] = 12'h63C;
        mem[1] = 12'h711;
        ack_delay = 3;
        stall_left = 4;
        pulse_start();
        begin
            int k = 0;
            while (ret_log.size() < 1 && k < 60) begin
                tick();
                if (instr_valid) chk("stall_pc_held", pc, 0);
                k++;
            end
        end
        chk("stall_retired", ret_log.size() >= 1, 1);
        chk("wait_req_cycles", req_ticks, 4);
        chk("stall_valid_cycles", valid_ticks, 5);
        @(posedge clk); #1;
        chk("stall_pc_after", pc, 1);

        // Jump and wrap
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[0]   = 12'h4FF;
        mem[255] = 12'h111;
        pulse_start();
        run_until_retired(2, 50);
        @(posedge clk); #1;
        chk("wrap_pc", pc, 0);
        begin
            int k = 0;
            while (fetch_log.size() < 3 && k < 10) begin
                tick();
                k++;
            end
        end
        chk("jmp_fetch_count", fetch_log.size() >= 3, 1);
        if (fetch_log.size() >= 3) begin
            chk("jmp_fetch0", fetch_log[0], 8'h00);
            chk("jmp_fetch1", fetch_log[1], 8'hFF);
            chk("wrap_fetch2", fetch_log[2], 8'h00);
        end
        if (ret_log.size() >= 2) begin
            chk("jmp_op", ret_log[0].op, 4'h4);
            chk("after_jmp_op", ret_log[1].op, 4'h1);
            chk("after_jmp_operand", ret_log[1].opnd, 8'h11);
        end

        // Halt
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[0] = 12'hF00;
        pulse_start();
        begin
            int k = 0;
            while (!halted && k < 20) begin
                tick();
                k++;
            end
        end
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_sticky", halted, 1);
            chk("halt_no_req", imem_req, 0);
            chk("halt_pc_hold", pc, 1);
        end
        do_reset();
        chk("rst_clears_halted", halted, 0);
        chk("rst_clears_pc", pc, 0);

        // Reset mid-fetch with a late ack
        do_reset();
        mem_en = 0;
        pulse_start();
        chk("midfetch_req_before", imem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midfetch_req_after_rst", imem_req, 0);
        chk("midfetch_valid_after_rst", instr_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 12'hABC;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 12'h000;
        prev_req = 0; prev_valid = 0; prev_ack = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("late_ack_valid", instr_valid, 0);
            chk("late_ack_req", imem_req, 0);
            chk("late_ack_opcode", opcode, 0);
            chk("late_ack_pc", pc, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
